// File: rtl/pad_io_ctrl_if.sv
// Pad-side bundle for pad_io_ctrl: core output controls, crossbar returns and debounced inputs.
// The master modport is the core/crossbar side; the slave modport is the pad controller.
interface pad_io_ctrl_if #(
    parameter int NPads = 70,
    parameter int CntW  = 8
);
    logic [NPads-1:0] drv_en_i;
    logic [NPads-1:0] out_i;
    logic [CntW-1:0]  db_thresh_i;
    logic [NPads-1:0] dq_i;
    logic [NPads-1:0] in_o;
    logic [NPads-1:0] rise_o;
    logic [NPads-1:0] fall_o;
    logic [NPads-1:0] oe_o;
    logic [NPads-1:0] outi_o;

    modport master (
        output drv_en_i, out_i, db_thresh_i, dq_i,
        input  in_o, rise_o, fall_o, oe_o, outi_o
    );

    modport slave (
        input  drv_en_i, out_i, db_thresh_i, dq_i,
        output in_o, rise_o, fall_o, oe_o, outi_o
    );
endinterface

// File: rtl/pad_io_ctrl.sv
// Per-pad I/O controller: registered output enable/data toward the crossbar and a
// synchronized, debounced input path with one-cycle rise/fall pulses.
module pad_io_ctrl #(
    parameter int NPads = 70,
    parameter int CntW  = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    pad_io_ctrl_if.slave pads
);

    // A threshold of zero is treated as one so a change always needs one full sample.
    function automatic logic [CntW:0] eff_thresh(input logic [CntW-1:0] t);
        return (t == '0) ? (CntW+1)'(1) : {1'b0, t};
    endfunction

    logic [NPads-1:0] oe_p0;
    logic [NPads-1:0] outi_p0;
    logic [NPads-1:0] sync1_p0;
    logic [NPads-1:0] sync2_p1;
    logic [NPads-1:0] state_p2;
    logic [NPads-1:0] rise_p2;
    logic [NPads-1:0] fall_p2;
    logic [CntW-1:0]  cnt_p2 [NPads];

    logic [CntW:0]    thresh;
    logic [NPads-1:0] mismatch;
    logic [NPads-1:0] commit;

    // >= rather than == so a threshold lowered mid-count still commits promptly.
    always_comb begin
        thresh   = eff_thresh(pads.db_thresh_i);
        mismatch = sync2_p1 ^ state_p2;
        commit   = '0;
        for (int k = 0; k < NPads; k++) begin
            commit[k] = mismatch[k] &&
                        (({1'b0, cnt_p2[k]} + (CntW+1)'(1)) >= thresh);
        end
    end

    // Stage p0: output path registers and first synchronizer flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oe_p0    <= '1;
            outi_p0  <= '0;
            sync1_p0 <= '0;
        end else begin
            oe_p0    <= ~pads.drv_en_i;
            outi_p0  <= pads.out_i;
            sync1_p0 <= ~pads.dq_i;
        end
    end

    // Stage p1: second synchronizer flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync2_p1 <= '0;
        end else begin
            sync2_p1 <= sync1_p0;
        end
    end

    // Stage p2: debounce counters, committed level and edge pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p2 <= '0;
            rise_p2  <= '0;
            fall_p2  <= '0;
            for (int k = 0; k < NPads; k++) begin
                cnt_p2[k] <= '0;
            end
        end else begin
            state_p2 <= state_p2 ^ commit;
            rise_p2  <= commit & sync2_p1;
            fall_p2  <= commit & ~sync2_p1;
            for (int k = 0; k < NPads; k++) begin
                if (!mismatch[k] || commit[k]) begin
                    cnt_p2[k] <= '0;
                end else begin
                    cnt_p2[k] <= cnt_p2[k] + CntW'(1);
                end
            end
        end
    end

    assign pads.oe_o   = oe_p0;
    assign pads.outi_o = outi_p0;
    assign pads.in_o   = state_p2;
    assign pads.rise_o = rise_p2;
    assign pads.fall_o = fall_p2;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Bench for pad_io_ctrl: constant-table vectors, directed debounce/reset sequences and
// randomized traffic compared against a sample-window reference model.
module tb_pad_io_ctrl;
    localparam int NP = 70;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pad_io_ctrl_if #(.NPads(NP), .CntW(CW)) bus ();

    pad_io_ctrl #(.NPads(NP), .CntW(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pads  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw pad level history, newest first, index 0 = level before this edge.
    logic [NP-1:0] raw_q [$];
    logic [NP-1:0] m_in, m_rise, m_fall, m_oe, m_outi;

    typedef struct {
        logic [NP-1:0] drv;
        logic [NP-1:0] out;
        logic [NP-1:0] exp_oe;
        logic [NP-1:0] exp_outi;
    } out_vec_t;

    typedef struct {
        int            pad;
        logic [CW-1:0] thr;
        int            exp_edge;
    } lat_vec_t;

    out_vec_t out_tab [5];
    lat_vec_t lat_tab [5];

    function automatic bit samp(int idx, int k);
        if (idx < raw_q.size()) return raw_q[idx][k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        raw_q.delete();
        m_in   = '0;
        m_rise = '0;
        m_fall = '0;
        m_oe   = '1;
        m_outi = '0;
    endtask

    // The level flips when the last T synchronized samples all disagree with it;
    // a sample reaches the debouncer two edges after it is presented.
    task automatic model_edge(input logic [NP-1:0] drv, input logic [NP-1:0] out,
                              input logic [NP-1:0] dq, input logic [CW-1:0] thr);
        int t;
        logic [NP-1:0] nin;
        bit all_diff;
        t = (thr == 0) ? 1 : int'(thr);
        raw_q.push_front(~dq);
        if (raw_q.size() > 300) void'(raw_q.pop_back());
        nin    = m_in;
        m_rise = '0;
        m_fall = '0;
        for (int k = 0; k < NP; k++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= t + 1; j++) begin
                if (samp(j, k) == m_in[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
                nin[k] = ~m_in[k];
                if (nin[k]) m_rise[k] = 1'b1;
                else        m_fall[k] = 1'b1;
            end
        end
        m_in   = nin;
        m_oe   = ~drv;
        m_outi = out;
    endtask

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".oe"},   bus.oe_o,   m_oe);
        check({tag, ".outi"}, bus.outi_o, m_outi);
        check({tag, ".in"},   bus.in_o,   m_in);
        check({tag, ".rise"}, bus.rise_o, m_rise);
        check({tag, ".fall"}, bus.fall_o, m_fall);
        check({tag, ".excl"}, bus.rise_o & bus.fall_o, '0);
    endtask

    task automatic tick();
        logic [NP-1:0] drv, out, dq;
        logic [CW-1:0] thr;
        drv = bus.drv_en_i;
        out = bus.out_i;
        dq  = bus.dq_i;
        thr = bus.db_thresh_i;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(drv, out, dq, thr);
        #1;
        check_all("model");
    endtask

    task automatic latency_case(input int pad, input logic [CW-1:0] thr, input int exp_edge);
        int n;
        bit seen;
        bus.db_thresh_i = thr;
        bus.dq_i[pad]   = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (bus.in_o[pad]) seen = 1'b1;
        end
        check_int("latency_edge", n, exp_edge);
        check_int("rise_on_change", int'(bus.rise_o[pad]), 1);
        tick();
        check_int("rise_one_cycle", int'(bus.rise_o[pad]), 0);
        bus.dq_i[pad] = 1'b1;
        repeat (exp_edge + 2) tick();
        check_int("back_low", int'(bus.in_o[pad]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_tab[0] = '{70'h1000, 70'h1000, 70'h3F_FFFF_FFFF_FFFF_EFFF, 70'h1000};
        out_tab[1] = '{70'h0, 70'h1000, 70'h3F_FFFF_FFFF_FFFF_FFFF, 70'h1000};
        out_tab[2] = '{70'h3F_FFFF_FFFF_FFFF_FFFF, 70'h0, 70'h0, 70'h0};
        out_tab[3] = '{70'h2A_AAAA_AAAA_AAAA_AAAA, 70'h15_5555_5555_5555_5555,
                       70'h15_5555_5555_5555_5555, 70'h15_5555_5555_5555_5555};
        out_tab[4] = '{70'h20_0000_0000_0000_0001, 70'h20_0000_0000_0000_0001,
                       70'h1F_FFFF_FFFF_FFFF_FFFE, 70'h20_0000_0000_0000_0001};
        lat_tab[0] = '{5, 8'd3, 5};
        lat_tab[1] = '{0, 8'd0, 3};
        lat_tab[2] = '{0, 8'd1, 3};
        lat_tab[3] = '{20, 8'd2, 4};
        lat_tab[4] = '{69, 8'd6, 8};

        bus.drv_en_i    = '1;
        bus.out_i       = '1;
        bus.dq_i        = '1;
        bus.db_thresh_i = 8'd2;
        model_reset();

        // Reset state with active inputs
        repeat (3) @(posedge clk);
        #1;
        check("rst.oe",   bus.oe_o,   '1);
        check("rst.outi", bus.outi_o, '0);
        check("rst.in",   bus.in_o,   '0);
        rst = 1'b0;
        bus.drv_en_i = '0;
        bus.out_i    = '0;
        repeat (10) tick();
        check("idle.in",   bus.in_o,   '0);
        check("idle.rise", bus.rise_o, '0);

        // Output path table
        for (int i = 0; i < 5; i++) begin
            bus.drv_en_i = out_tab[i].drv;
            bus.out_i    = out_tab[i].out;
            tick();
            check("tab.oe",   bus.oe_o,   out_tab[i].exp_oe);
            check("tab.outi", bus.outi_o, out_tab[i].exp_outi);
        end

        // Debounce latency table
        for (int i = 0; i < 5; i++) begin
            latency_case(lat_tab[i].pad, lat_tab[i].thr, lat_tab[i].exp_edge);
        end

        // Short pulse rejection, twice in a row to expose a counter that does not clear
        bus.db_thresh_i = 8'd4;
        for (int r = 0; r < 2; r++) begin
            bus.dq_i[9] = 1'b0;
            repeat (3) tick();
            bus.dq_i[9] = 1'b1;
            repeat (8) tick();
            check_int("glitch_rejected", int'(bus.in_o[9]), 0);
        end

        // Threshold lowered mid-count commits on the next mismatching edge
        bus.db_thresh_i = 8'd200;
        bus.dq_i[3] = 1'b0;
        repeat (52) tick();
        check_int("long_count_hold", int'(bus.in_o[3]), 0);
        bus.db_thresh_i = 8'd10;
        tick();
        check_int("thr_drop_commit", int'(bus.in_o[3]), 1);
        check_int("thr_drop_rise",   int'(bus.rise_o[3]), 1);

        // Asynchronous reset mid-count on pad 7
        bus.db_thresh_i = 8'd200;
        bus.drv_en_i = '1;
        bus.out_i    = '1;
        bus.dq_i[7]  = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.in",   bus.in_o,   '0);
        check("async_rst.oe",   bus.oe_o,   '1);
        check("async_rst.outi", bus.outi_o, '0);
        check("async_rst.rise", bus.rise_o, '0);
        repeat (2) tick();
        rst = 1'b0;
        bus.db_thresh_i = 8'd10;
        begin
            int n;
            n = 0;
            while (!bus.in_o[7] && n < 300) begin
                tick();
                n++;
            end
            check_int("fresh_rise_edge", n, 12);
            check_int("fresh_rise_pad3", int'(bus.in_o[3]), 1);
        end
        bus.dq_i = '1;
        bus.db_thresh_i = 8'd2;
        repeat (20) tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [95:0] r1, r2;
            r1 = {$urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom};
            bus.drv_en_i = r1[NP-1:0];
            bus.out_i    = r2[NP-1:0];
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(5) == 0) bus.dq_i[k] = ~bus.dq_i[k];
            end
            if (c % 50 == 0) bus.db_thresh_i = CW'($urandom_range(5));
            if (c == 300) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_rst");
                repeat (2) tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 SHALL have parameter NPads, default 70, the number of bidirectional pads served; valid range 1..70.
REQ-002 SHALL have parameter CntW, default 8, the debounce counter width in bits.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port drv_en_i, input, NPads bits: 1 = core drives pad k.
REQ-006 SHALL have port out_i, input, NPads bits: core output data.
REQ-007 SHALL have port db_thresh_i, input, CntW bits: debounce threshold in cycles, quasi-static.
REQ-008 SHALL have port in_o, output, NPads bits: debounced pad input level.
REQ-009 SHALL have port rise_o, output, NPads bits: one-cycle pulse on a 0->1 change of in_o[k].
REQ-010 SHALL have port fall_o, output, NPads bits: one-cycle pulse on a 1->0 change of in_o[k].
REQ-011 SHALL have port oe_o, output, NPads bits, to pad crossbar oe: 1 = pad released (high-Z), 0 = pad driven.
REQ-012 SHALL have port outi_o, output, NPads bits: to pad crossbar outi.
REQ-013 SHALL have port dq_i, input, NPads bits: from pad crossbar dq; carries the inverted pad level.

Function
REQ-014 SHALL register the output path: oe_o[k] <= ~drv_en_i[k] and outi_o[k] <= out_i[k], giving 1 cycle of latency.
REQ-015 SHALL form the raw input as ~dq_i[k] and pass it through a 2-flop synchronizer (sync1, sync2) per pad.
REQ-016 SHALL keep, per pad, a CntW-bit counter cnt[k] and a debounced state in_o[k].
REQ-017 SHALL hold an effective threshold T = max(db_thresh_i, 1), so a value of 0 behaves as 1.
REQ-018 SHALL, each cycle where sync2[k] == in_o[k], set cnt[k] <= 0.
REQ-019 SHALL, each cycle where sync2[k] != in_o[k] and cnt[k]+1 >= T, set in_o[k] <= sync2[k] and cnt[k] <= 0.
REQ-020 SHALL, each cycle where sync2[k] != in_o[k] and cnt[k]+1 < T, set cnt[k] <= cnt[k]+1; cnt never wraps because it clears at T-1 or earlier.
REQ-021 SHALL compare with >= so that lowering db_thresh_i mid-count below cnt[k]+1 commits the new level on the next mismatching cycle.
REQ-022 SHALL give input latency as follows: a stable level change on pad k set up before edge 1 appears on in_o[k] after edge T+2.
REQ-023 SHALL reject any raw pulse shorter than T cycles at sync2: in_o is unchanged and cnt returns to 0.
REQ-024 SHALL register rise_o[k] and fall_o[k] so they assert in the same cycle in_o[k] changes, for exactly 1 cycle; rise and fall are never both 1 for a pad.
REQ-025 SHALL keep pads fully independent, with no cross-pad interaction; simultaneous changes on all pads are handled in parallel.
REQ-026 SHALL keep the input path active regardless of drv_en_i; the value presented by dq_i is debounced as-is.
REQ-027 SHALL tie unused upper bits to 0 on outputs and ignore them on inputs when NPads < 70.

Reset
REQ-028 SHALL, while rst_i = 1 (asynchronously), hold oe_o = all 1s (all pads released), outi_o = 0, sync1 = sync2 = 0, in_o = 0, cnt = 0, rise_o = 0, fall_o = 0.
REQ-029 SHALL, on rst_i assertion mid-debounce, discard pending counts; a pad level of 1 after release is reported as a fresh rise, T+2 cycles later.
REQ-030 SHALL deassert rst_i synchronously to clk_i at the system level; the block contains no reset synchronizer.

Verification
REQ-031 SHALL cover: reset asserted -> oe_o = all 1s, outi_o = 0, in_o = 0; with dq_i = all 1s (pads low) held after release -> in_o stays 0, with no pulses.
REQ-032 SHALL cover: db_thresh_i = 3, dq_i[5] 1->0 held -> in_o[5] = 1 after edge 5, rise_o[5] high for exactly that cycle.
REQ-033 SHALL cover: db_thresh_i = 4, dq_i[9] low for 3 cycles then high -> in_o[9] stays 0 and cnt[9] returns to 0.
REQ-034 SHALL cover: db_thresh_i = 0, toggle dq_i[0] -> in_o[0] follows after edge 3, identical to the db_thresh_i = 1 case.
REQ-035 SHALL cover: drv_en_i[12] = 1, out_i[12] = 1 -> oe_o[12] = 0, outi_o[12] = 1 one cycle later; drv_en_i[12] = 0 -> oe_o[12] = 1.
REQ-036 SHALL cover: db_thresh_i = 200 with pad 3 at cnt = 50, change db_thresh_i to 10 -> in_o[3] updates on the next cycle; then assert rst_i mid-count on pad 7 -> all state clears immediately.
